// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the bit-serial add sequencer.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned SERIAL_N = 4;

    // Bit counter only needs to reach N-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One full-adder cell with its carry flop; the carry is forced to cin_load_i
// when a new operand pair is loaded.
module serial_fa_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic cin_load_i,
    input  logic en_i,
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic cout_o
);

    logic c_q;

    assign s_o    = a_i ^ b_i ^ c_q;
    assign cout_o = (a_i & b_i) | (a_i & c_q) | (b_i & c_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_q <= 1'b0;
        end else if (load_i) begin
            c_q <= cin_load_i;
        end else if (en_i) begin
            c_q <= cout_o;
        end
    end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: parallel operands in, LSB-first add over N cycles,
// (N+1)-bit sum out. Define SERIAL_SUB_EN to add the 'sub' port (a - b).
module serial_add_seq
    import serial_pkg::*;
#(
    parameter int unsigned N = SERIAL_N
) (
    input  logic         CLK,
    input  logic         rst_n,
`ifdef SERIAL_SUB_EN
    input  logic         sub,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   sum,
    output logic         busy
);

    localparam int unsigned CW = cnt_width(N);

    state_t        state_q, state_d;
    logic [N-1:0]  ra_q, ra_d;
    logic [N-1:0]  rb_q, rb_d;
    logic [N-2:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    sum_q, sum_d;

    logic [N-1:0]  b_load;
    logic          cin_load;
    logic          load;
    logic          shift_en;
    logic          s_bit;
    logic          c_next;
    logic [N-1:0]  collected;

`ifdef SERIAL_SUB_EN
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub;
`else
    assign b_load   = b;
    assign cin_load = 1'b0;
`endif

    serial_fa_cell u_fa (
        .clk_i      (CLK),
        .rst_ni     (rst_n),
        .load_i     (load),
        .cin_load_i (cin_load),
        .en_i       (shift_en),
        .a_i        (ra_q[0]),
        .b_i        (rb_q[0]),
        .s_o        (s_bit),
        .cout_o     (c_next)
    );

    // New bit enters at the MSB; after N shifts bit 0 has reached the LSB.
    assign collected = {s_bit, res_q};

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = b_load;
                    cnt_d   = '0;
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                ra_d     = {1'b0, ra_q[N-1:1]};
                rb_d     = {1'b0, rb_q[N-1:1]};
                res_d    = collected[N-1:1];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = {c_next, collected};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: accepts push a model result, the
// monitor pops and compares on each output handshake.
module tb_serial_add_seq;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [N:0]   sum;
    logic         sub_sel = 1'b0;
`ifdef SERIAL_SUB_EN
    logic         sub;
    assign sub = sub_sel;
`endif

    always #5 CLK = ~CLK;

    serial_add_seq #(.N(N)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
`ifdef SERIAL_SUB_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_acc = -1000;
    logic [N:0] exp_q[$];
    int         acc_edges[$];
    logic       prev_ov = 1'b0;
    logic [N:0] prev_sum = '0;
    logic       or_rand = 1'b0;
    logic       or_force = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Unsigned add with full carry-out; subtract is a + (2^N-1-b) + 1.
    function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        int unsigned r;
        if (s) r = int'(x) + ((2 ** N) - 1 - int'(y)) + 1;
        else   r = int'(x) + int'(y);
        return r[N:0];
    endfunction

    always @(posedge CLK) cyc = cyc + 1;

    always @(posedge CLK) begin
        #2;
        out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_force;
    end

    always @(negedge CLK) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, sub_sel));
            acc_edges.push_back(cyc + 1);
            last_acc = cyc + 1;
        end
    end

    always @(negedge CLK) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            chk("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (out_valid && !prev_ov) chk("latency", cyc - last_acc, N);
            if (out_valid && prev_ov)  chk("sum_hold", 32'(sum), 32'(prev_sum));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got sum %0h, expected no output", sum);
                end else begin
                    chk("sum", 32'(sum), 32'(exp_q.pop_front()));
                end
            end
            prev_ov  = out_valid;
            prev_sum = sum;
        end
    end

    task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic ts, input bit keep);
        bit ok = 0;
        a        = ta;
        b        = tb_v;
        sub_sel  = ts;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                @(posedge CLK);
                #1;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept, expected accept within 40 cycles");
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n;
        bit seen;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(sum), 0);
        rst_n = 1'b1;
        or_force = 1'b1;
        @(posedge CLK);
        #1;

        // Basic add with busy duration
        issue(4'b1001, 4'b1010, 1'b0, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (busy) n++;
            else break;
        end
        chk("busy_cycles", n, N + 1);
        drain();

        issue(4'b1111, 4'b0001, 1'b0, 0);
        drain();
        issue(4'b1111, 4'b1111, 1'b0, 0);
        drain();

        // Backpressure
        or_force = 1'b0;
        issue(4'b1001, 4'b1010, 1'b0, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_out_valid_seen", 32'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", 32'(sum), 32'b10011);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        or_force = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 1);
        chk("bp_release_out_valid", 32'(out_valid), 0);
        drain();

        // Reset two cycles into SHIFT
        issue(4'b0110, 4'b0111, 1'b0, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        issue(4'b0011, 4'b0101, 1'b0, 0);
        drain();

        // Back-to-back with in_valid held high
        acc_edges.delete();
        for (int k = 0; k < 5; k++) begin
            issue(N'($urandom), N'($urandom), 1'b0, 1);
        end
        in_valid = 1'b0;
        drain();
        for (int k = 1; k < acc_edges.size(); k++) begin
            chk("b2b_spacing", acc_edges[k] - acc_edges[k-1], N + 2);
        end
        chk("b2b_count", acc_edges.size(), 5);

`ifdef SERIAL_SUB_EN
        issue(4'b1001, 4'b1010, 1'b1, 0);
        drain();
        issue(4'b1010, 4'b1001, 1'b1, 0);
        drain();
`endif

        // Randomized operands with random backpressure
        or_rand = 1'b1;
        for (int k = 0; k < 25; k++) begin
`ifdef SERIAL_SUB_EN
            issue(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 0);
`else
            issue(N'($urandom), N'($urandom), 1'b0, 0);
`endif
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
        end
        or_rand = 1'b0;
        or_force = 1'b1;
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
